// File: rtl/w_sram_to_arow_pf.sv
// Prefetching W-SRAM column-slice gatherer: streams M-row slices for a burst of
// columns into an NBUF-deep ring of slots and presents them to the array A-row port.
module w_sram_to_arow_pf #(
  parameter  int unsigned M      = 8,
  parameter  int unsigned KMAX   = 1024,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned BYTE_W = DATA_W/8,
  parameter  int unsigned NBUF   = 2,
  localparam int unsigned ROW_W  = (M <= 1) ? 1 : $clog2(M),
  localparam int unsigned K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_base,
  input  logic [K_W:0]      k_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              arow_valid,
  input  logic              arow_accept,
  output logic [K_W-1:0]    arow_k,
  output logic              arow_last,
  output logic [DATA_W-1:0] a_row [M],
  output logic              w_en,
  output logic              w_re,
  output logic              w_we,
  output logic [ROW_W-1:0]  w_row,
  output logic [K_W-1:0]    w_k,
  output logic [DATA_W-1:0] w_wdata,
  output logic [BYTE_W-1:0] w_wmask,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic              w_rvalid
);

  localparam int unsigned PTR_W = $clog2(NBUF);
  localparam int unsigned OUT_W = $clog2(NBUF*M + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [K_W-1:0]          r_k_base;
  logic [K_W:0]            r_k_cnt;
  logic [K_W:0]            r_iss_col;
  logic [ROW_W-1:0]        r_iss_row, r_rx_row;
  logic [PTR_W-1:0]        r_iss_ptr, r_rx_ptr, r_hd_ptr;
  logic [NBUF-1:0]         r_filling, r_full, r_slot_last;
  logic [K_W-1:0]          r_slot_k    [NBUF];
  logic [M-1:0][DATA_W-1:0] r_slot_data [NBUF];
  logic [OUT_W-1:0]        r_outst;
  logic                    r_err;

  logic           w_start_ok, w_slot_free, w_mid_slice, w_issue, w_row_end;
  logic           w_rx_ok, w_rx_end, w_acc, w_acc_last;
  logic [K_W-1:0] w_col;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NBUF-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_slot_free = !r_filling[r_iss_ptr] && !r_full[r_iss_ptr];
  assign w_mid_slice = (r_iss_row != '0);
  // A slice, once begun, is issued back-to-back; stalls happen only at row 0.
  assign w_issue     = (r_state == S_RUN) &&
                       (w_mid_slice || ((r_iss_col != r_k_cnt) && w_slot_free));
  assign w_row_end   = (r_iss_row == ROW_W'(M-1));
  assign w_col       = r_k_base + r_iss_col[K_W-1:0];
  assign w_rx_ok     = w_rvalid && (r_outst != '0);
  assign w_rx_end    = (r_rx_row == ROW_W'(M-1));
  assign w_acc       = r_full[r_hd_ptr] && arow_accept;
  assign w_acc_last  = w_acc && r_slot_last[r_hd_ptr];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (k_cnt == '0) ? S_FIN : S_RUN;
      S_RUN:   if (w_acc_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k_base    <= '0;
      r_k_cnt     <= '0;
      r_iss_col   <= '0;
      r_iss_row   <= '0;
      r_rx_row    <= '0;
      r_iss_ptr   <= '0;
      r_rx_ptr    <= '0;
      r_hd_ptr    <= '0;
      r_filling   <= '0;
      r_full      <= '0;
      r_slot_last <= '0;
      r_outst     <= '0;
      r_err       <= 1'b0;
      for (int unsigned b = 0; b < NBUF; b++) begin
        r_slot_k[b]    <= '0;
        r_slot_data[b] <= '0;
      end
    end else begin
      if (w_start_ok) begin
        r_k_base  <= k_base;
        r_k_cnt   <= k_cnt;
        r_iss_col <= '0;
        r_iss_row <= '0;
      end

      if (w_issue) begin
        if (!w_mid_slice) begin
          r_filling[r_iss_ptr]   <= 1'b1;
          r_slot_k[r_iss_ptr]    <= w_col;
          r_slot_last[r_iss_ptr] <= ((r_iss_col + 1'b1) == r_k_cnt);
        end
        if (w_row_end) begin
          r_iss_row <= '0;
          r_iss_col <= r_iss_col + 1'b1;
          r_iss_ptr <= ptr_inc(r_iss_ptr);
        end else begin
          r_iss_row <= r_iss_row + 1'b1;
        end
      end

      // Receiving slot is FILLING and head slot is FULL, so these never collide.
      if (w_rx_ok) begin
        r_slot_data[r_rx_ptr][r_rx_row] <= w_rdata;
        if (w_rx_end) begin
          r_filling[r_rx_ptr] <= 1'b0;
          r_full[r_rx_ptr]    <= 1'b1;
          r_rx_ptr            <= ptr_inc(r_rx_ptr);
          r_rx_row            <= '0;
        end else begin
          r_rx_row <= r_rx_row + 1'b1;
        end
      end

      if (w_acc) begin
        r_full[r_hd_ptr] <= 1'b0;
        r_hd_ptr         <= ptr_inc(r_hd_ptr);
      end

      case ({w_issue, w_rx_ok})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase

      if (w_rvalid && (r_outst == '0)) r_err <= 1'b1;
      else if (w_start_ok)             r_err <= 1'b0;
    end
  end

  assign busy       = (r_state == S_RUN) || (r_state == S_FIN);
  assign done       = (r_state == S_FIN);
  assign err        = r_err;
  assign arow_valid = r_full[r_hd_ptr];
  assign arow_k     = r_slot_k[r_hd_ptr];
  assign arow_last  = r_slot_last[r_hd_ptr];
  assign w_en       = w_issue;
  assign w_re       = w_issue;
  assign w_we       = 1'b0;
  assign w_row      = r_iss_row;
  assign w_k        = w_col;
  assign w_wdata    = '0;
  assign w_wmask    = '0;

  always_comb begin
    for (int unsigned r = 0; r < M; r++) a_row[r] = r_slot_data[r_hd_ptr][r];
  end

endmodule

// File: tb/tb_w_sram_to_arow_pf.sv
// Directed bench for w_sram_to_arow_pf with a 2-cycle SRAM model whose word at
// (row r, column k) is 0xA000_0000 + (r<<16) + k.
module tb_w_sram_to_arow_pf;

  localparam int unsigned M      = 8;
  localparam int unsigned KMAX   = 1024;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 4;
  localparam int unsigned NBUF   = 2;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned K_W    = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [K_W-1:0]    k_base = '0;
  logic [K_W:0]      k_cnt = '0;
  logic              busy, done, err, arow_valid, arow_last;
  logic              arow_accept = 1'b0;
  logic [K_W-1:0]    arow_k;
  logic [DATA_W-1:0] a_row [M];
  logic              w_en, w_re, w_we;
  logic [ROW_W-1:0]  w_row;
  logic [K_W-1:0]    w_k;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  logic [BYTE_W-1:0] w_wmask;
  logic              w_rvalid;

  always #5 clk = ~clk;

  w_sram_to_arow_pf #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W), .BYTE_W(BYTE_W), .NBUF(NBUF)) dut (
    .clk(clk), .rst(rst), .start(start), .k_base(k_base), .k_cnt(k_cnt),
    .busy(busy), .done(done), .err(err), .arow_valid(arow_valid),
    .arow_accept(arow_accept), .arow_k(arow_k), .arow_last(arow_last), .a_row(a_row),
    .w_en(w_en), .w_re(w_re), .w_we(w_we), .w_row(w_row), .w_k(w_k),
    .w_wdata(w_wdata), .w_wmask(w_wmask), .w_rdata(w_rdata), .w_rvalid(w_rvalid)
  );

  function automatic logic [31:0] exp_w(input logic [ROW_W-1:0] r, input logic [K_W-1:0] k);
    return 32'hA000_0000 + ({29'd0, r} << 16) + {22'd0, k};
  endfunction

  // SRAM model: not reset, so reads in flight survive a DUT reset
  logic             s1_v = 1'b0, s2_v = 1'b0;
  logic [ROW_W-1:0] s1_r = '0, s2_r = '0;
  logic [K_W-1:0]   s1_k = '0, s2_k = '0;
  always @(posedge clk) begin
    s1_v <= (w_en === 1'b1);
    s1_r <= w_row;
    s1_k <= w_k;
    s2_v <= s1_v;
    s2_r <= s1_r;
    s2_k <= s1_k;
  end
  assign w_rvalid = s2_v;
  assign w_rdata  = exp_w(s2_r, s2_k);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0, n_bad = 0;
  logic        mon_clr = 1'b0;
  int          n_acc = 0, n_done = 0, n_wen = 0;
  int          first_wen = -1, last_wen = -1, first_valid = -1, done_cyc = -1, busy_fall = -1;
  int          acc_k [16], acc_last [16], acc_cyc [16];
  logic        acc_ok [16];
  logic [31:0] acc_d0 [16], acc_d7 [16];
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_acc = 0; n_done = 0; n_wen = 0;
      first_wen = -1; last_wen = -1; first_valid = -1; done_cyc = -1; busy_fall = -1;
    end else begin
      if (arow_valid && arow_accept && n_acc < 16) begin
        acc_k[n_acc]    = int'(arow_k);
        acc_last[n_acc] = int'(arow_last);
        acc_cyc[n_acc]  = cyc;
        acc_d0[n_acc]   = a_row[0];
        acc_d7[n_acc]   = a_row[M-1];
        acc_ok[n_acc]   = 1'b1;
        for (int unsigned r = 0; r < M; r++)
          if (a_row[r] !== exp_w(ROW_W'(r), arow_k)) acc_ok[n_acc] = 1'b0;
        n_acc++;
      end
      if (w_en === 1'b1) begin
        if (first_wen < 0) first_wen = cyc;
        last_wen = cyc;
        n_wen++;
      end
      if (arow_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (done === 1'b1) begin
        done_cyc = cyc;
        n_done++;
      end
      if (prev_busy && busy === 1'b0) busy_fall = cyc;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic launch(input int kb, input int kc, output int t0);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(posedge clk);
    #2;
    k_base = K_W'(kb);
    k_cnt  = (K_W+1)'(kc);
    start  = 1'b1;
    t0     = cyc;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n_done == 0 && n < 500) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(n_done > 0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    // Reset state
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_valid", 64'(arow_valid), 64'd0);
    chk("rst_wen", 64'({w_en, w_re, w_we}), 64'd0);
    chk("rst_arow_k", 64'(arow_k), 64'd0);
    chk("rst_last", 64'(arow_last), 64'd0);
    chk("rst_arow0", 64'(a_row[0]), 64'd0);
    chk("rst_arow7", 64'(a_row[M-1]), 64'd0);
    rst = 1'b0;
    tick(2);

    // Single slice, consumer always ready
    arow_accept = 1'b1;
    launch(0, 1, t0);
    wait_done("t1");
    chk("t1_nacc", 64'(n_acc), 64'd1);
    chk("t1_k", 64'(acc_k[0]), 64'd0);
    chk("t1_last", 64'(acc_last[0]), 64'd1);
    chk("t1_d0", 64'(acc_d0[0]), 64'hA000_0000);
    chk("t1_d7", 64'(acc_d7[0]), 64'hA007_0000);
    chk("t1_data", 64'(acc_ok[0]), 64'd1);
    chk("t1_wen_lat", 64'(first_wen - t0), 64'd1);
    chk("t1_valid_lat", 64'(first_valid - t0), 64'(M + 3));
    chk("t1_done_lat", 64'(done_cyc - acc_cyc[0]), 64'd1);
    tick(3);
    chk("t1_busy_fall", 64'(busy_fall - done_cyc), 64'd1);

    // Four columns at full rate
    launch(5, 4, t0);
    wait_done("t2");
    chk("t2_nacc", 64'(n_acc), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_k%0d", i), 64'(acc_k[i]), 64'(5 + i));
      chk($sformatf("t2_last%0d", i), 64'(acc_last[i]), 64'(i == 3));
      chk($sformatf("t2_data%0d", i), 64'(acc_ok[i]), 64'd1);
      if (i > 0) chk($sformatf("t2_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(M));
    end
    chk("t2_d7_k8", 64'(acc_d7[3]), 64'hA007_0008);
    chk("t2_nwen", 64'(n_wen), 64'(4 * M));
    chk("t2_wen_contig", 64'(last_wen - first_wen + 1), 64'(4 * M));
    chk("t2_done_lat", 64'(done_cyc - acc_cyc[3]), 64'd1);

    // Back-pressure: consumer withholds accept for 50 cycles
    arow_accept = 1'b0;
    launch(20, 4, t0);
    tick(15);
    chk("t3_valid_early", 64'(arow_valid), 64'd1);
    chk("t3_k_early", 64'(arow_k), 64'd20);
    chk("t3_d0_early", 64'(a_row[0]), 64'hA000_0014);
    tick(35);
    chk("t3_nwen_stall", 64'(n_wen), 64'(2 * M));
    chk("t3_k_late", 64'(arow_k), 64'd20);
    chk("t3_d3_late", 64'(a_row[3]), 64'hA003_0014);
    chk("t3_busy", 64'(busy), 64'd1);
    arow_accept = 1'b1;
    wait_done("t3");
    chk("t3_nacc", 64'(n_acc), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_k%0d", i), 64'(acc_k[i]), 64'(20 + i));
      chk($sformatf("t3_data%0d", i), 64'(acc_ok[i]), 64'd1);
    end
    chk("t3_nwen", 64'(n_wen), 64'(4 * M));

    // Column wrap past KMAX-1
    launch(1022, 3, t0);
    wait_done("t4");
    chk("t4_nacc", 64'(n_acc), 64'd3);
    chk("t4_k0", 64'(acc_k[0]), 64'd1022);
    chk("t4_k1", 64'(acc_k[1]), 64'd1023);
    chk("t4_k2", 64'(acc_k[2]), 64'd0);
    chk("t4_d7_k1023", 64'(acc_d7[1]), 64'hA007_03FF);
    chk("t4_d0_k0", 64'(acc_d0[2]), 64'hA000_0000);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_data%0d", i), 64'(acc_ok[i]), 64'd1);
    chk("t4_last2", 64'(acc_last[2]), 64'd1);

    // Empty burst
    launch(3, 0, t0);
    wait_done("t5");
    chk("t5_nwen", 64'(n_wen), 64'd0);
    chk("t5_done_lat", 64'(done_cyc - t0), 64'd1);
    chk("t5_nacc", 64'(n_acc), 64'd0);

    // Start while busy is ignored
    launch(40, 3, t0);
    tick(4);
    k_base = 10'd9;
    k_cnt  = 11'd2;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    wait_done("t6");
    tick(20);
    chk("t6_nacc", 64'(n_acc), 64'd3);
    chk("t6_k0", 64'(acc_k[0]), 64'd40);
    chk("t6_k1", 64'(acc_k[1]), 64'd41);
    chk("t6_k2", 64'(acc_k[2]), 64'd42);
    chk("t6_ndone", 64'(n_done), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);

    // Reset mid-burst leaves reads in flight, which then arrive as strays
    arow_accept = 1'b0;
    launch(0, 2, t0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t7_busy_abort", 64'(busy), 64'd0);
    chk("t7_valid_abort", 64'(arow_valid), 64'd0);
    tick(5);
    chk("t7_err", 64'(err), 64'd1);
    arow_accept = 1'b1;
    launch(100, 2, t0);
    chk("t7_err_clr", 64'(err), 64'd0);
    wait_done("t7");
    chk("t7_nacc", 64'(n_acc), 64'd2);
    chk("t7_k0", 64'(acc_k[0]), 64'd100);
    chk("t7_k1", 64'(acc_k[1]), 64'd101);
    chk("t7_data0", 64'(acc_ok[0]), 64'd1);
    chk("t7_data1", 64'(acc_ok[1]), 64'd1);
    chk("t7_err_end", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/w_sram_to_arow_pf.md
# w_sram_to_arow_pf

Prefetching successor of the single-shot W-SRAM row gatherer. It reads an M-element column slice, row 0..M-1 at column k, from the weight SRAM for a burst of consecutive k values. Each slice is assembled into one of NBUF ring-buffer slots, and the slots are presented in order to the systolic array's A-row input over a valid/accept handshake. SRAM reads for k+1 overlap with the array's consumption of k, which removes the per-k fill bubble between the SRAM port and the array front-end.

## Interface
- M, 8: rows per slice (array height); ROW_W = (M<=1)?1:$clog2(M)
- KMAX, 1024: column depth of W SRAM; K_W = (KMAX<=1)?1:$clog2(KMAX)
- DATA_W, 32: word width
- BYTE_W, DATA_W/8: write-mask width
- NBUF, 2: slice buffers, ≥2

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  burst request, sampled only in IDLE
- k_base  in  K_W  first column of burst
- k_cnt  in  K_W+1  number of columns in burst, 0..KMAX
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- err  out  1  sticky: w_rvalid with no read outstanding; cleared by accepted start
- arow_valid  out  1  head slot full
- arow_accept  in  1  consumer takes head slot
- arow_k  out  K_W  column of head slot
- arow_last  out  1  head slot is final column of burst
- a_row  out  [M] x DATA_W  head slot contents, a_row[r] = W[r][arow_k]
- w_en, w_re  out  1  SRAM read request, both high together
- w_we  out  1  tied 0
- w_row  out  ROW_W  read row
- w_k  out  K_W  read column
- w_wdata  out  DATA_W  tied 0
- w_wmask  out  BYTE_W  tied 0
- w_rdata  in  DATA_W  read data
- w_rvalid  in  1  read data valid; responses in issue order, any latency ≥1

## Operation
- FSM: IDLE -> RUN on start && k_cnt!=0. IDLE -> FIN on start && k_cnt==0, with no reads issued. RUN -> FIN when the last slice is accepted. FIN -> IDLE unconditionally. done=1 only in FIN. busy=1 in RUN and FIN.
- Start while busy is ignored. k_base and k_cnt are latched at start.
- Issuer:
  - A slot is free when not FILLING and not FULL.
  - While columns remain and the slot at issue pointer is free, the issuer marks it FILLING and issues rows 0..M-1 for the current column, one per cycle, with no gaps.
  - It then advances the column and the issue pointer (mod NBUF).
  - The issuer stalls at row 0 only, never mid-slice.
- Column arithmetic is k_base + i mod 2^K_W. Wrap past KMAX-1 is legal.
- Receiver:
  - Keeps its own (slot, row) pointer, advanced on each w_rvalid.
  - Writes w_rdata into slot[row].
  - After row M-1 the slot becomes FULL and the receive pointer advances.
  - A w_rvalid with zero reads outstanding is dropped and sets err.
- Output:
  - arow_valid = head slot FULL.
  - a_row, arow_k and arow_last come from the head slot and are stable while valid && !accept.
  - arow_valid && arow_accept frees the head slot and advances the head pointer.
  - The freed slot is eligible for issue on the next cycle.
  - arow_accept with arow_valid=0 is ignored.
- Outstanding reads are bounded by NBUF*M. The counter is sized accordingly.

## Timing
- Reset values: every output is 0, a_row is all 0, and all slots are free. Reset mid-burst aborts immediately; later stray w_rvalid sets err.
- start sampled at edge T0: first w_en in cycle T0+1.
- With the 2-cycle SRAM model (request in cycle c, rvalid in c+2):
  - Row r of slice 0 is issued in cycle T0+1+r and returns in T0+3+r.
  - arow_valid rises in cycle T0+M+3.
  - Slice 1 is issued in cycles T0+M+1..T0+2M with no bubble.
  - With NBUF=2 and no accept, issue of slice 2 stalls until the cycle after slice 0 is accepted.
- Sustained throughput with prompt accept: one slice per M cycles.
- done pulses in the cycle after the accept of the arow_last slice; busy falls the cycle after done.
- Simultaneous accept of the head and return of the last row into another slot: both take effect; the valid handoff is gap-free if that slot is next.

## Test plan
- Burst k_base=0, k_cnt=1, accept on valid:
  - a_row[r] = 0xA000_0000 + (r<<16).
  - arow_last=1.
  - arow_valid rises at T0+M+3.
  - done one cycle after accept.
- Burst k_base=5, k_cnt=4, accept held high: four slices with k=5..8 in order, each 8 cycles apart after the first, no w_en gap, arow_last only on k=8.
- Burst k_cnt=4, accept withheld 50 cycles:
  - Exactly 2*M reads are issued, then w_en stays low.
  - a_row/arow_k for k of the first slice are stable.
  - Releasing accept completes all 4 slices.
- Wrap: k_base=1022, k_cnt=3 → arow_k 1022, 1023, 0, with data matching each column.
- k_cnt=0: no w_en, done pulses at T0+1. Start during busy ignored (a second start with k_base=9 mid-burst does not change arow_k sequence).
- Reset mid-burst then a pending rvalid → err=1. Next start clears err and the burst is correct.
